seg14_scan_decoder: RTL
=======================

# seg14_scan_decoder

Receive-side counterpart of the 12-digit multiplexed 14-segment display scanner. It samples the one-hot digit select and the 14-bit segment pattern every clock and decodes each pattern to a 5-bit character code. It tracks the scan sequence digit 0 → digit 11 and publishes a complete 12-character frame with a one-cycle valid strobe. It sits on the loopback/self-test path next to the display driver, letting firmware or a bench read back what the panel is showing.

## Interface
- `N_DIGITS`, 12, number of scanned digits; only 12 is supported.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sel` input 12: one-hot digit select from the scanner; bit k = digit k; all-zero = blank.
- `segm` input 14: segment pattern; bit 13 = segment a.
- `frame` output 60: committed frame; digit k code at bits [5k+4:5k].
- `frame_valid` output 1: one-cycle pulse when `frame` is updated.
- `frame_glyph_err` output 1: committed frame contained at least one unknown glyph.
- `seq_err` output 1: one-cycle pulse on a scan-order violation while locked.
- `locked` output 1: high while in TRACK.

## Operation
- Glyph table, code=pattern. 0=11111100001001, 1=01100000001000, 2=11011011000000, 3=11110001000000, 4=01100111000000.
- Digits continued. 5=10110111000000, 6=10111111000000, 7=11100000000000, 8=11111111000000, 9=11110111000000.
- Letters. A(10)=11101111000000, B(11)=11110001010010, C(12)=10011100000000, D(13)=11110000010010, E(14)=10011110000000, F(15)=10001110000000, J(16)=01111000000000.
- Space. space(17)=00000000000000.
- Any other pattern decodes to 31 and sets the per-frame glyph-error accumulator.
- Inputs are registered once (`sel_q`, `segm_q`). All decisions use the registered values.
- A `sel_q` with more than one bit set is "bad". A `sel_q` of zero is "blank" and is ignored in every state.
- The 12×5 shadow buffer is internal; `cur` is the current digit index, 0–11; `done` marks that digit 11 has been committed.
- State HUNT, `sel_q` = digit 0: write shadow[0], clear the accumulator, set `cur`=0, clear `done`, go to TRACK.
- State HUNT, any other value: ignore it; no `seq_err`.
- State TRACK, index == `cur` and `done`=0: overwrite shadow[`cur`]. This is a held digit.
- State TRACK, index == `cur`=11 and `done`=1: ignore.
- State TRACK, index == `cur`+1 and `cur`<11: write shadow[index] and set `cur`=index.
- State TRACK, index == 11 (reached by either of the two previous rules) and `done`=0: commit. `frame` ← shadow with the digit-11 write included. `frame_glyph_err` ← accumulator including this digit. Pulse `frame_valid`. Set `done`.
- State TRACK, index 0 and `cur`=11: start a new frame. Write shadow[0], clear the accumulator, set `cur`=0, clear `done`.
- State TRACK, bad `sel_q` or any other index: pulse `seq_err`, go to HUNT, discard the shadow. `frame` keeps its last committed value.
- Mid-frame errors never alter `frame`, `frame_valid` or `frame_glyph_err`.

## Timing
- Reset values: `frame` = all 17 (space), `frame_valid`=0, `frame_glyph_err`=0, `seq_err`=0, `locked`=0, state HUNT, `sel_q`/`segm_q`=0.
- Latency: inputs present before edge E are captured into `sel_q` at E. The resulting `frame`/`frame_valid`/`seq_err` update occurs at E+1.
- Overall: from the digit-11 sample at the pins to `frame_valid` high is 2 edges.
- `locked` rises at the edge that acts on digit 0 in HUNT. It falls at the edge that pulses `seq_err`.
- Supports one digit per clock and digits held for any number of clocks, with any number of blanks between digits.
- Reset asserted mid-frame: everything returns to reset values at that edge; the partial frame is lost.

## Test plan
- Scan J,J,C,C,2,2,0,4,2,0,0,1 at one digit per clock, twice -> `frame_valid` pulses at 2 and 14 cycles after digit 11 first enters. `frame` codes d0..d11 = 16,16,12,12,2,2,0,4,2,0,0,1. `frame_glyph_err`=0. `seq_err` never asserts.
- Same scan with each digit held 3 clocks and 2 blank clocks between digits -> one `frame_valid` per frame with identical codes.
- Start mid-scan at digit 5 after reset -> no `seq_err`, `locked`=0 until digit 0. The first `frame_valid` follows the next digit 11.
- Skip from digit 3 to digit 5 while locked -> `seq_err` pulse, `locked`=0, `frame` unchanged. The next full scan commits normally.
- `sel`=000000000011 while locked -> `seq_err` pulse. Digit 7 pattern 11111111111111 in a full scan -> d7=31 and `frame_glyph_err`=1. The next clean frame clears it to 0.
- Assert `rst` during digit 6 -> all outputs return to reset values next cycle. `frame` = all 17.

Source files
------------

// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder
// Watches the drive side of a 12-digit multiplexed 14-segment display and
// rebuilds the characters being shown. Each sampled segment pattern is
// decoded to a 5-bit character code. The scan order digit 0 -> digit 11 is
// tracked, and each complete frame is published with a one-cycle strobe.
//
// Ports
//   clk             : single clock, rising edge
//   rst             : synchronous active-high reset
//   sel[11:0]       : one-hot digit select (bit k = digit k, zero = blank)
//   segm[13:0]      : segment pattern, bit 13 = segment a
//   frame[59:0]     : committed frame, digit k code at [5k+4:5k]
//   frame_valid     : one-cycle pulse when frame is updated
//   frame_glyph_err : committed frame held at least one unknown glyph
//   seq_err         : one-cycle pulse on a scan-order violation while locked
//   locked          : high while tracking a scan
module seg14_scan_decoder #(
  parameter int N_DIGITS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   sel,
  input  logic [13:0]           segm,
  output logic [5*N_DIGITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  frame_glyph_err,
  output logic                  seq_err,
  output logic                  locked
);

  localparam logic [3:0] LAST = 4'(N_DIGITS - 1);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t                 state;
  logic [N_DIGITS-1:0]    sel_q;
  logic [13:0]            segm_q;
  logic [3:0]             cur;
  logic                   done;
  logic                   acc;
  logic [5*N_DIGITS-1:0]  shadow;

  // Decode of the registered segment pattern.
  logic [4:0] code;
  logic       unk;
  always_comb begin
    code = 5'd31;
    unk  = 1'b0;
    case (segm_q)
      14'b11111100001001: code = 5'd0;
      14'b01100000001000: code = 5'd1;
      14'b11011011000000: code = 5'd2;
      14'b11110001000000: code = 5'd3;
      14'b01100111000000: code = 5'd4;
      14'b10110111000000: code = 5'd5;
      14'b10111111000000: code = 5'd6;
      14'b11100000000000: code = 5'd7;
      14'b11111111000000: code = 5'd8;
      14'b11110111000000: code = 5'd9;
      14'b11101111000000: code = 5'd10;
      14'b11110001010010: code = 5'd11;
      14'b10011100000000: code = 5'd12;
      14'b11110000010010: code = 5'd13;
      14'b10011110000000: code = 5'd14;
      14'b10001110000000: code = 5'd15;
      14'b01111000000000: code = 5'd16;
      14'b00000000000000: code = 5'd17;
      default:            unk  = 1'b1;
    endcase
  end

  // Digit index of the registered select plus a population count, so a
  // select with several bits set can be told apart from a single digit.
  logic [3:0] idx;
  logic [3:0] n_set;
  logic       blank;
  logic       bad;
  always_comb begin
    idx   = 4'd0;
    n_set = 4'd0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (sel_q[k]) begin
        idx   = 4'(k);
        n_set = n_set + 4'd1;
      end
    end
    blank = (n_set == 4'd0);
    bad   = (n_set > 4'd1);
  end

  // Shadow with the current sample written into its slot; also the value
  // committed to frame when digit 11 is written.
  logic [5*N_DIGITS-1:0] shadow_wr;
  int                    idx_i;
  always_comb begin
    idx_i     = int'(idx);
    shadow_wr = shadow;
    shadow_wr[5*idx_i +: 5] = code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= HUNT;
      sel_q           <= '0;
      segm_q          <= '0;
      cur             <= 4'd0;
      done            <= 1'b0;
      acc             <= 1'b0;
      shadow          <= {N_DIGITS{5'd17}};
      frame           <= {N_DIGITS{5'd17}};
      frame_valid     <= 1'b0;
      frame_glyph_err <= 1'b0;
      seq_err         <= 1'b0;
      locked          <= 1'b0;
    end else begin
      sel_q       <= sel;
      segm_q      <= segm;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      case (state)
        HUNT: begin
          // Only a clean digit 0 starts tracking; everything else is noise.
          if (!blank && !bad && idx == 4'd0) begin
            shadow <= shadow_wr;
            acc    <= unk;
            cur    <= 4'd0;
            done   <= 1'b0;
            state  <= TRACK;
            locked <= 1'b1;
          end
        end
        TRACK: begin
          if (!blank) begin
            if (!bad && idx == cur && !done) begin
              // Held digit: refresh its slot.
              shadow <= shadow_wr;
              acc    <= acc | unk;
              if (idx == LAST) begin
                frame           <= shadow_wr;
                frame_glyph_err <= acc | unk;
                frame_valid     <= 1'b1;
                done            <= 1'b1;
              end
            end else if (!bad && idx == cur && done) begin
              // Digit 11 still held after its commit.
            end else if (!bad && cur < LAST && idx == cur + 4'd1) begin
              shadow <= shadow_wr;
              acc    <= acc | unk;
              cur    <= idx;
              if (idx == LAST) begin
                frame           <= shadow_wr;
                frame_glyph_err <= acc | unk;
                frame_valid     <= 1'b1;
                done            <= 1'b1;
              end
            end else if (!bad && idx == 4'd0 && cur == LAST) begin
              shadow <= shadow_wr;
              acc    <= unk;
              cur    <= 4'd0;
              done   <= 1'b0;
            end else begin
              // Out-of-order or multi-hot select: drop the partial frame.
              seq_err <= 1'b1;
              state   <= HUNT;
              locked  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
